// File: rtl/uart_cmd_ctrl.sv
// Command FIFO and register-bus sequencer between the UART hex decoder and the bus.
// Define UART_CMD_TIMEOUT_EN to build the bus timeout path (response code 11).
module uart_cmd_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  input  logic        CMD_R,
  input  logic        CMD_W,
  input  logic        CMD_FAIL,
  input  logic [7:0]  CMD_ADDR,
  input  logic [31:0] CMD_DATA,
  output logic        CMD_FULL,
  output logic [7:0]  DROP_CNT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [7:0]  BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [1:0]  RSP_CODE,
  output logic [31:0] RSP_DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state, state_next;
  logic [42:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic            push, pop, cmd_bad, bus_timeout;
  logic [42:0]     head;

  assign push    = CMD_VALID && (count != FULL_CNT);
  assign head    = fifo_mem[rd_ptr];
  assign cmd_bad = head[40] || (head[42] == head[41]);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {CMD_R, CMD_W, CMD_FAIL, CMD_ADDR, CMD_DATA};
  end

  // Overflow is judged on the pre-edge count, so a same-edge pop never rescues a full push.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      CMD_FULL <= 1'b0;
      DROP_CNT <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      CMD_FULL <= (count_next == FULL_CNT);
      if (CMD_VALID && (count == FULL_CNT) && (DROP_CNT != 8'hFF))
        DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  logic [15:0] timer;

  assign bus_timeout = (timer == TIMER_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                timer <= 16'd0;
    else if (state != BUS)  timer <= 16'd0;
    else if (!bus_timeout)  timer <= timer + 16'd1;
  end
`else
  assign bus_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = cmd_bad ? RESP : BUS;
        end
      end
      BUS:     if (BUS_ACK || bus_timeout) state_next = RESP;
      RESP:    if (RSP_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ACK is tested before the timeout so a same-cycle ACK always wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BUS_REQ   <= 1'b0;
      BUS_WE    <= 1'b0;
      BUS_ADDR  <= 8'd0;
      BUS_WDATA <= 32'd0;
      RSP_VALID <= 1'b0;
      RSP_CODE  <= 2'b00;
      RSP_DATA  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (cmd_bad) begin
              RSP_VALID <= 1'b1;
              RSP_CODE  <= 2'b10;
              RSP_DATA  <= 32'd0;
            end else begin
              BUS_REQ   <= 1'b1;
              BUS_WE    <= head[41];
              BUS_ADDR  <= head[39:32];
              BUS_WDATA <= head[31:0];
            end
          end
        end
        BUS: begin
          if (BUS_ACK) begin
            BUS_REQ   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_CODE  <= BUS_WE ? 2'b00 : 2'b01;
            RSP_DATA  <= BUS_WE ? 32'd0 : BUS_RDATA;
          end else if (bus_timeout) begin
            BUS_REQ   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_CODE  <= 2'b11;
            RSP_DATA  <= 32'd0;
          end
        end
        RESP:    if (RSP_READY) RSP_VALID <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (DEPTH=4, TIMEOUT=8).
module tb_uart_cmd_ctrl;

  logic        CLK, RST;
  logic        CMD_VALID, CMD_R, CMD_W, CMD_FAIL;
  logic [7:0]  CMD_ADDR;
  logic [31:0] CMD_DATA;
  logic        CMD_FULL;
  logic [7:0]  DROP_CNT;
  logic        BUS_REQ, BUS_WE;
  logic [7:0]  BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic        BUS_ACK;
  logic [31:0] BUS_RDATA;
  logic        RSP_VALID, RSP_READY;
  logic [1:0]  RSP_CODE;
  logic [31:0] RSP_DATA;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_cmd_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_R(CMD_R), .CMD_W(CMD_W), .CMD_FAIL(CMD_FAIL),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .CMD_FULL(CMD_FULL), .DROP_CNT(DROP_CNT),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_CODE(RSP_CODE), .RSP_DATA(RSP_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic send_cmd(input logic r, input logic w, input logic f,
                          input logic [7:0] a, input logic [31:0] d);
    CMD_VALID = 1'b1; CMD_R = r; CMD_W = w; CMD_FAIL = f; CMD_ADDR = a; CMD_DATA = d;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; CMD_R = 1'b0; CMD_W = 1'b0; CMD_FAIL = 1'b0;
  endtask

  // Waits for BUS_REQ, counts its high cycles and raises ACK in cycle ack_after (0 = never).
  task automatic run_bus(input int ack_after, input logic [31:0] rdata,
                         output int req_cycles, output logic [7:0] addr, output logic we,
                         output logic [31:0] wdata, output int rise_cyc);
    int guard = 0;
    req_cycles = 0;
    while (BUS_REQ !== 1'b1 && guard < 50) begin
      @(posedge CLK); #1; guard++;
    end
    rise_cyc = cyc;
    addr = BUS_ADDR; we = BUS_WE; wdata = BUS_WDATA;
    guard = 0;
    while (BUS_REQ === 1'b1 && guard < 100) begin
      req_cycles++;
      if (ack_after != 0 && req_cycles == ack_after) begin
        BUS_ACK = 1'b1; BUS_RDATA = rdata;
      end
      @(posedge CLK); #1; guard++;
    end
    BUS_ACK = 1'b0; BUS_RDATA = 32'd0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    CMD_VALID = 0; CMD_R = 0; CMD_W = 0; CMD_FAIL = 0; CMD_ADDR = 0; CMD_DATA = 0;
    BUS_ACK = 0; BUS_RDATA = 0; RSP_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (BUS_REQ !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %0h expected 0", BUS_REQ); end
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %0h expected 0", RSP_VALID); end
    n_checks++; if (CMD_FULL !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %0h expected 0", CMD_FULL); end
    n_checks++; if (DROP_CNT !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_drop: got %0h expected 0", DROP_CNT); end
    n_checks++; if ({RSP_CODE, RSP_DATA, BUS_ADDR, BUS_WDATA, BUS_WE} !== 75'd0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got code %0h data %0h addr %0h wdata %0h we %0h expected all 0",
                         RSP_CODE, RSP_DATA, BUS_ADDR, BUS_WDATA, BUS_WE);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_write;
    int cycles, rise, start;
    logic [7:0] a; logic we; logic [31:0] wd;
    RSP_READY = 1'b1;
    send_cmd(1'b0, 1'b1, 1'b0, 8'h3A, 32'hDEADBEEF);
    start = cyc;
    n_checks++; if (BUS_REQ !== 1'b0) begin n_fail++; $display("[TB] FAIL write_req_early: got %0h expected 0", BUS_REQ); end
    run_bus(3, 32'h0, cycles, a, we, wd, rise);
    n_checks++; if (rise - start !== 1) begin n_fail++; $display("[TB] FAIL write_latency: got %0d expected 1", rise - start); end
    n_checks++; if (cycles !== 3) begin n_fail++; $display("[TB] FAIL write_req_cycles: got %0d expected 3", cycles); end
    n_checks++; if ({we, a, wd} !== {1'b1, 8'h3A, 32'hDEADBEEF}) begin
      n_fail++; $display("[TB] FAIL write_bus_fields: got we %0h addr %0h wdata %0h expected 1 3a deadbeef", we, a, wd);
    end
    n_checks++; if ({RSP_VALID, RSP_CODE, RSP_DATA} !== {1'b1, 2'b00, 32'd0}) begin
      n_fail++; $display("[TB] FAIL write_rsp: got valid %0h code %0h data %0h expected 1 0 0", RSP_VALID, RSP_CODE, RSP_DATA);
    end
    @(posedge CLK); #1;
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL write_rsp_drop: got %0h expected 0", RSP_VALID); end
  endtask

  task automatic test_read;
    int cycles, rise, held;
    logic [7:0] a; logic we; logic [31:0] wd;
    RSP_READY = 1'b0;
    send_cmd(1'b1, 1'b0, 1'b0, 8'h05, 32'h0);
    run_bus(1, 32'h12345678, cycles, a, we, wd, rise);
    n_checks++; if ({we, a} !== {1'b0, 8'h05}) begin n_fail++; $display("[TB] FAIL read_bus_fields: got we %0h addr %0h expected 0 05", we, a); end
    n_checks++; if ({RSP_VALID, RSP_CODE, RSP_DATA} !== {1'b1, 2'b01, 32'h12345678}) begin
      n_fail++; $display("[TB] FAIL read_rsp: got valid %0h code %0h data %0h expected 1 1 12345678", RSP_VALID, RSP_CODE, RSP_DATA);
    end
    held = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP_VALID === 1'b1 && RSP_CODE === 2'b01 && RSP_DATA === 32'h12345678) held++;
    end
    n_checks++; if (held !== 5) begin n_fail++; $display("[TB] FAIL read_rsp_hold: got %0d cycles expected 5", held); end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL read_rsp_drop: got %0h expected 0", RSP_VALID); end
  endtask

  task automatic test_bad;
    int rsp_seen = 0, wrong = 0, req_seen = 0;
    RSP_READY = 1'b1;
    send_cmd(1'b0, 1'b1, 1'b1, 8'h11, 32'h1);
    send_cmd(1'b1, 1'b1, 1'b0, 8'h22, 32'h2);
    for (int i = 0; i < 8; i++) begin
      if (RSP_VALID === 1'b1) begin
        rsp_seen++;
        if (RSP_CODE !== 2'b10 || RSP_DATA !== 32'd0) wrong++;
      end
      if (BUS_REQ !== 1'b0) req_seen++;
      @(posedge CLK); #1;
    end
    n_checks++; if (rsp_seen !== 2) begin n_fail++; $display("[TB] FAIL bad_rsp_count: got %0d expected 2", rsp_seen); end
    n_checks++; if (wrong !== 0) begin n_fail++; $display("[TB] FAIL bad_rsp_code: got %0d wrong responses expected 0", wrong); end
    n_checks++; if (req_seen !== 0) begin n_fail++; $display("[TB] FAIL bad_bus_touched: got %0d req cycles expected 0", req_seen); end
  endtask

  task automatic test_back_to_back;
    int c1, c2, r1, r2;
    logic [7:0] a1, a2; logic we; logic [31:0] wd;
    RSP_READY = 1'b1;
    send_cmd(1'b0, 1'b1, 1'b0, 8'h41, 32'hA);
    send_cmd(1'b0, 1'b1, 1'b0, 8'h42, 32'hB);
    run_bus(1, 32'h0, c1, a1, we, wd, r1);
    run_bus(1, 32'h0, c2, a2, we, wd, r2);
    n_checks++; if ({a1, a2} !== {8'h41, 8'h42}) begin n_fail++; $display("[TB] FAIL b2b_order: got %0h %0h expected 41 42", a1, a2); end
    n_checks++; if (r2 - r1 !== 3) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected 3", r2 - r1); end
    @(posedge CLK); #1;
  endtask

  task automatic test_timeout;
    int cycles, rise;
    logic [7:0] a; logic we; logic [31:0] wd;
    RSP_READY = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
    send_cmd(1'b1, 1'b0, 1'b0, 8'h77, 32'h0);
    run_bus(0, 32'h0, cycles, a, we, wd, rise);
    n_checks++; if (cycles !== 8) begin n_fail++; $display("[TB] FAIL tmo_req_cycles: got %0d expected 8", cycles); end
    n_checks++; if ({RSP_VALID, RSP_CODE, RSP_DATA} !== {1'b1, 2'b11, 32'd0}) begin
      n_fail++; $display("[TB] FAIL tmo_rsp: got valid %0h code %0h data %0h expected 1 3 0", RSP_VALID, RSP_CODE, RSP_DATA);
    end
    @(posedge CLK); #1;
    send_cmd(1'b1, 1'b0, 1'b0, 8'h78, 32'h0);
    run_bus(8, 32'hCAFE0001, cycles, a, we, wd, rise);
    n_checks++; if (cycles !== 8) begin n_fail++; $display("[TB] FAIL tmo_ack_cycles: got %0d expected 8", cycles); end
    n_checks++; if ({RSP_VALID, RSP_CODE, RSP_DATA} !== {1'b1, 2'b01, 32'hCAFE0001}) begin
      n_fail++; $display("[TB] FAIL tmo_ack_rsp: got valid %0h code %0h data %0h expected 1 1 cafe0001", RSP_VALID, RSP_CODE, RSP_DATA);
    end
`else
    send_cmd(1'b0, 1'b1, 1'b0, 8'h66, 32'h6);
    run_bus(20, 32'h0, cycles, a, we, wd, rise);
    n_checks++; if (cycles !== 20) begin n_fail++; $display("[TB] FAIL no_tmo_req_cycles: got %0d expected 20", cycles); end
    n_checks++; if ({RSP_VALID, RSP_CODE} !== {1'b1, 2'b00}) begin
      n_fail++; $display("[TB] FAIL no_tmo_rsp: got valid %0h code %0h expected 1 0", RSP_VALID, RSP_CODE);
    end
`endif
    @(posedge CLK); #1;
  endtask

  task automatic test_overflow;
    int cycles, rise;
    logic [7:0] a; logic we; logic [31:0] wd;
    RSP_READY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_cmd(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i), 32'(i));
      if (i == 3) begin
        n_checks++; if (CMD_FULL !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_full_early: got %0h expected 0", CMD_FULL); end
      end
      if (i == 4) begin
        n_checks++; if ({CMD_FULL, DROP_CNT} !== {1'b1, 8'd0}) begin
          n_fail++; $display("[TB] FAIL ovf_full: got full %0h drop %0d expected 1 0", CMD_FULL, DROP_CNT);
        end
      end
    end
    n_checks++; if ({CMD_FULL, DROP_CNT} !== {1'b1, 8'd1}) begin
      n_fail++; $display("[TB] FAIL ovf_drop: got full %0h drop %0d expected 1 1", CMD_FULL, DROP_CNT);
    end
    RSP_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_bus(1, 32'h0, cycles, a, we, wd, rise);
      n_checks++; if ({a, wd} !== {8'h10 + 8'(k), 32'(k)}) begin
        n_fail++; $display("[TB] FAIL ovf_drain_%0d: got addr %0h wdata %0h expected %0h %0h", k, a, wd, 8'h10 + 8'(k), k);
      end
    end
    @(posedge CLK); #1;
    n_checks++; if ({CMD_FULL, DROP_CNT} !== {1'b0, 8'd1}) begin
      n_fail++; $display("[TB] FAIL ovf_after_drain: got full %0h drop %0d expected 0 1", CMD_FULL, DROP_CNT);
    end
  endtask

  task automatic test_mid_reset;
    int activity = 0;
    RSP_READY = 1'b0;
    send_cmd(1'b1, 1'b0, 1'b0, 8'h90, 32'h0);
    send_cmd(1'b0, 1'b1, 1'b0, 8'h91, 32'h1);
    send_cmd(1'b0, 1'b1, 1'b0, 8'h92, 32'h2);
    n_checks++; if (BUS_REQ !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_req_before: got %0h expected 1", BUS_REQ); end
    #2 RST = 1'b1;
    #1;
    n_checks++; if ({BUS_REQ, RSP_VALID, DROP_CNT, CMD_FULL} !== 11'd0) begin
      n_fail++; $display("[TB] FAIL rst_async: got req %0h valid %0h drop %0d full %0h expected all 0", BUS_REQ, RSP_VALID, DROP_CNT, CMD_FULL);
    end
    #2 RST = 1'b0;
    RSP_READY = 1'b1;
    repeat (10) begin
      @(posedge CLK); #1;
      if (BUS_REQ !== 1'b0 || RSP_VALID !== 1'b0) activity++;
    end
    n_checks++; if (activity !== 0) begin n_fail++; $display("[TB] FAIL rst_queue_flushed: got %0d active cycles expected 0", activity); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
